// File: rtl/spc_ram_loader_pkg.sv
// Shared definitions for the SPC700 boot loader: state encodings, default hold time,
// and the running image checksum helper.
package spc_ram_loader_pkg;

    typedef enum logic [3:0] {
        ST_ADDR_LO = 4'd0,
        ST_ADDR_HI = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_LEN_HI  = 4'd3,
        ST_PAYLOAD = 4'd4,
        ST_CSUM    = 4'd5,
        ST_HOLD    = 4'd6,
        ST_RUN     = 4'd7,
        ST_ERROR   = 4'd8
    } loader_state_t;

    localparam int HOLD_CYCLES_DEFAULT = 4;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/spc_ram_port_mux.sv
// Single-master selector for the audio RAM port: loader while the CPU is held,
// CPU (zero latency) once it runs.
module spc_ram_port_mux #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  cpu_run,
    input  logic [ADDR_WIDTH-1:0] loader_address,
    input  logic [7:0]            loader_write,
    input  logic                  loader_write_enable,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [7:0]            cpu_write,
    input  logic                  cpu_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]            ram_write,
    output logic                  ram_write_enable
);

    // Select the bus owner; CPU strobes are dropped while the loader owns the RAM.
    always_comb begin
        ram_address      = loader_address;
        ram_write        = loader_write;
        ram_write_enable = loader_write_enable;
        if (cpu_run) begin
            ram_address      = cpu_address;
            ram_write        = cpu_write;
            ram_write_enable = cpu_write_enable;
        end else begin
            ram_address      = loader_address;
            ram_write        = loader_write;
            ram_write_enable = loader_write_enable;
        end
    end

endmodule

// File: rtl/spc_ram_loader.sv
// Boot loader: parses a little-endian {addr, len, payload} byte stream into RAM, then
// releases the CPU. Optional image checksum via `define SPC_LOADER_CHECKSUM_EN.
module spc_ram_loader
    import spc_ram_loader_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [ADDR_WIDTH-1:0] in_cpu_address,
    input  logic [7:0]            in_cpu_write,
    input  logic                  in_cpu_write_enable,
    output logic [ADDR_WIDTH-1:0] out_ram_address,
    output logic [7:0]            out_ram_write,
    output logic                  out_ram_write_enable,
    output logic                  out_cpu_run,
    output logic                  out_error
);

    localparam logic [7:0]            HOLD_LOAD = 8'(HOLD_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    loader_state_t         state_r;
    logic                  ready_r;
    logic                  run_r;
    logic [ADDR_WIDTH-1:0] ld_addr_r;
    logic [7:0]            ld_data_r;
    logic                  ld_we_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [7:0]            addr_lo_r;
    logic [7:0]            len_lo_r;
    logic [15:0]           remain_r;
    logic [7:0]            hold_cnt_r;
    logic                  accept_s;
`ifdef SPC_LOADER_CHECKSUM_EN
    logic [7:0]            csum_r;
    logic                  error_r;
`endif

    assign accept_s = in_valid && ready_r;

    // Loader FSM with pointer, remaining count, hold timer and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= ST_ADDR_LO;
            ready_r    <= 1'b0;
            run_r      <= 1'b0;
            ld_addr_r  <= {ADDR_WIDTH{1'b0}};
            ld_data_r  <= 8'h00;
            ld_we_r    <= 1'b0;
            ptr_r      <= {ADDR_WIDTH{1'b0}};
            addr_lo_r  <= 8'h00;
            len_lo_r   <= 8'h00;
            remain_r   <= 16'h0000;
            hold_cnt_r <= 8'h00;
`ifdef SPC_LOADER_CHECKSUM_EN
            csum_r     <= 8'h00;
            error_r    <= 1'b0;
`endif
        end else begin
            ld_we_r <= 1'b0;
`ifdef SPC_LOADER_CHECKSUM_EN
            if (accept_s) begin
                csum_r <= csum_update(csum_r, in_byte);
            end
`endif
            case (state_r)
                ST_ADDR_LO: begin
                    ready_r <= 1'b1;
                    if (accept_s) begin
                        addr_lo_r <= in_byte;
                        state_r   <= ST_ADDR_HI;
                    end
                end
                ST_ADDR_HI: begin
                    if (accept_s) begin
                        ptr_r   <= ADDR_WIDTH'({in_byte, addr_lo_r});
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_lo_r <= in_byte;
                        state_r  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        remain_r <= {in_byte, len_lo_r};
                        if ({in_byte, len_lo_r} == 16'h0000) begin
`ifdef SPC_LOADER_CHECKSUM_EN
                            state_r    <= ST_CSUM;
`else
                            state_r    <= ST_HOLD;
                            ready_r    <= 1'b0;
                            hold_cnt_r <= HOLD_LOAD;
`endif
                        end else begin
                            state_r <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept_s) begin
                        ld_we_r   <= 1'b1;
                        ld_addr_r <= ptr_r;
                        ld_data_r <= in_byte;
                        ptr_r     <= ptr_r + ADDR_ONE;
                        remain_r  <= remain_r - 16'd1;
                        if (remain_r == 16'd1) begin
`ifdef SPC_LOADER_CHECKSUM_EN
                            state_r    <= ST_CSUM;
`else
                            state_r    <= ST_HOLD;
                            ready_r    <= 1'b0;
                            hold_cnt_r <= HOLD_LOAD;
`endif
                        end
                    end
                end
`ifdef SPC_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept_s) begin
                        ready_r <= 1'b0;
                        if (csum_update(csum_r, in_byte) == 8'h00) begin
                            state_r    <= ST_HOLD;
                            hold_cnt_r <= HOLD_LOAD;
                        end else begin
                            state_r <= ST_ERROR;
                            error_r <= 1'b1;
                        end
                    end
                end
`endif
                // Release on the cycle the timer would reach zero, so run rises
                // exactly HOLD_CYCLES cycles after the final write strobe.
                ST_HOLD: begin
                    ready_r <= 1'b0;
                    if (hold_cnt_r <= 8'd1) begin
                        state_r <= ST_RUN;
                        run_r   <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 8'd1;
                    end
                end
                ST_RUN: begin
                    ready_r <= 1'b0;
                    run_r   <= 1'b1;
                end
                ST_ERROR: begin
                    ready_r <= 1'b0;
                    run_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_ERROR;
                    ready_r <= 1'b0;
                    run_r   <= 1'b0;
                end
            endcase
        end
    end

    assign out_ready   = ready_r;
    assign out_cpu_run = run_r;
`ifdef SPC_LOADER_CHECKSUM_EN
    assign out_error   = error_r;
`else
    assign out_error   = 1'b0;
`endif

    spc_ram_port_mux #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mux (
        .cpu_run             (run_r),
        .loader_address      (ld_addr_r),
        .loader_write        (ld_data_r),
        .loader_write_enable (ld_we_r),
        .cpu_address         (in_cpu_address),
        .cpu_write           (in_cpu_write),
        .cpu_write_enable    (in_cpu_write_enable),
        .ram_address         (out_ram_address),
        .ram_write           (out_ram_write),
        .ram_write_enable    (out_ram_write_enable)
    );

endmodule

// File: tb/tb_spc_ram_loader.sv
// Scoreboard bench for spc_ram_loader: expected RAM writes are queued as images are
// issued; a negedge monitor checks writes, release timing and handshakes.
module tb_spc_ram_loader;

    localparam int HOLD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [15:0] in_cpu_address = 16'h0000;
    logic [7:0]  in_cpu_write = 8'h00;
    logic        in_cpu_write_enable = 1'b0;
    logic [15:0] out_ram_address;
    logic [7:0]  out_ram_write;
    logic        out_ram_write_enable;
    logic        out_cpu_run;
    logic        out_error;

    spc_ram_loader #(.HOLD_CYCLES(HOLD), .ADDR_WIDTH(16)) dut (
        .clock                (clock),
        .reset                (reset),
        .in_byte              (in_byte),
        .in_valid             (in_valid),
        .out_ready            (out_ready),
        .in_cpu_address       (in_cpu_address),
        .in_cpu_write         (in_cpu_write),
        .in_cpu_write_enable  (in_cpu_write_enable),
        .out_ram_address      (out_ram_address),
        .out_ram_write        (out_ram_write),
        .out_ram_write_enable (out_ram_write_enable),
        .out_cpu_run          (out_cpu_run),
        .out_error            (out_error)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;

    int   checks = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    logic [7:0] payload_q[$];
    int   cyc = 0;
    int   acc_cnt = 0;
    int   img_total = 0;
    int   rel_exp = -1;
    logic prev_run = 1'b0;
    wr_t  mon_e;

    // Monitor: loader writes against the queue, release timing, accepted-byte count.
    always @(negedge clock) begin
        cyc++;
        if (out_ram_write_enable === 1'b1 && out_cpu_run !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected got addr=%h data=%h required no write", out_ram_address, out_ram_write);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_ram_address !== mon_e.a || out_ram_write !== mon_e.d) begin
                    failures++;
                    $display("FAIL wr_data got addr=%h data=%h required addr=%h data=%h",
                             out_ram_address, out_ram_write, mon_e.a, mon_e.d);
                end
            end
        end
        if (out_cpu_run === 1'b1 && prev_run !== 1'b1) begin
            checks++;
            if (cyc != rel_exp) begin
                failures++;
                $display("FAIL run_rise_cycle got cycle=%0d required cycle=%0d", cyc, rel_exp);
            end
        end
        prev_run = out_cpu_run;
        if (reset !== 1'b1) begin
            acc_cnt = 0;
            rel_exp = -1;
        end else if (in_valid && out_ready === 1'b1) begin
            acc_cnt++;
            if (acc_cnt == img_total) rel_exp = cyc + 1 + HOLD;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0; in_cpu_write_enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready", 32'(out_ready), 32'd0);
        chk("rst_run", 32'(out_cpu_run), 32'd0);
        chk("rst_we", 32'(out_ram_write_enable), 32'd0);
        chk("rst_addr", 32'(out_ram_address), 32'd0);
        chk("rst_data", 32'(out_ram_write), 32'd0);
        chk("rst_error", 32'(out_error), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit gap);
        bit ok = 1'b0;
        in_cpu_address = 16'($urandom);
        in_cpu_write = 8'($urandom);
        in_cpu_write_enable = 1'($urandom_range(0, 1));
        if (gap) begin
            in_valid = 1'b0; in_byte = 8'($urandom);
            @(posedge clock); #1;
        end
        in_byte = b; in_valid = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clock);
            if (out_ready === 1'b1) ok = 1'b1;
            @(posedge clock); #1;
        end
        in_valid = 1'b0; in_byte = 8'($urandom);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL handshake got no accept within 40 cycles required accept of %h", b);
        end
    endtask

    // gap_mode: 0 none, 1 idle cycle before every payload byte, 2 random idles
    task automatic send_image(input logic [15:0] start, input int len, input int gap_mode,
                              input int abort_after, input bit bad_csum);
        logic [7:0] cs;
        logic [7:0] hdr[4];
        bit g;
        hdr[0] = start[7:0]; hdr[1] = start[15:8];
        hdr[2] = 8'(len); hdr[3] = 8'(len >> 8);
        img_total = 4 + len;
`ifdef SPC_LOADER_CHECKSUM_EN
        img_total = img_total + 1;
`endif
        cs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            g = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            push_byte(hdr[i], g);
            cs = cs ^ hdr[i];
        end
        for (int i = 0; i < len; i++) begin
            if (i == abort_after) return;
            exp_q.push_back({16'(start + 16'(i)), payload_q[i]});
            g = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            push_byte(payload_q[i], g);
            cs = cs ^ payload_q[i];
        end
`ifdef SPC_LOADER_CHECKSUM_EN
        push_byte(bad_csum ? (cs ^ 8'h01) : cs, 1'b0);
`else
        if (bad_csum) $display("note: checksum feature disabled, bad_csum ignored");
`endif
        in_cpu_write_enable = 1'b0;
    endtask

    task automatic wait_run(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clock);
            if (out_cpu_run === 1'b1) seen = 1'b1;
        end
        chk({name, "_run"}, 32'(out_cpu_run), 32'd1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_ready"}, 32'(out_ready), 32'd0);
        chk({name, "_error"}, 32'(out_error), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic cpu_check(input logic [15:0] a, input logic [7:0] d, input logic we);
        in_cpu_address = a; in_cpu_write = d; in_cpu_write_enable = we;
        @(negedge clock);
        chk("mux_addr", 32'(out_ram_address), 32'(a));
        chk("mux_data", 32'(out_ram_write), 32'(d));
        chk("mux_we", 32'(out_ram_write_enable), 32'(we));
        @(posedge clock); #1;
    endtask

    task automatic rand_payload(input int len);
        payload_q.delete();
        for (int i = 0; i < len; i++) payload_q.push_back(8'($urandom));
    endtask

    initial begin
        logic [15:0] st;
        int          ln;
        do_reset();

        payload_q = '{8'hAA, 8'hBB, 8'hCC};
        send_image(16'h0200, 3, 0, -1, 1'b0);
        wait_run("img_0200");
        for (int k = 0; k < 4; k++) cpu_check(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        do_reset();
        payload_q = '{8'h11, 8'h22, 8'h33};
        send_image(16'hFFFE, 3, 0, -1, 1'b0);
        wait_run("img_wrap");

        do_reset();
        payload_q.delete();
        send_image(16'h4000, 0, 0, -1, 1'b0);
        wait_run("img_len0");
        cpu_check(16'h1234, 8'h5E, 1'b1);

        do_reset();
        rand_payload(6);
        send_image(16'($urandom), 6, 1, -1, 1'b0);
        wait_run("img_toggle");

        do_reset();
        rand_payload(5);
        send_image(16'h0300, 5, 0, 2, 1'b0);
        do_reset();
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        rand_payload(4);
        send_image(16'h0800, 4, 0, -1, 1'b0);
        wait_run("img_after_abort");

        for (int n = 0; n < 4; n++) begin
            do_reset();
            st = (n == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
            ln = $urandom_range(1, 24);
            rand_payload(ln);
            send_image(st, ln, 2, -1, 1'b0);
            wait_run("img_rand");
        end

        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_byte = 8'($urandom);
            @(negedge clock);
            chk("run_ignores_stream", 32'(out_ready), 32'd0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        cpu_check(16'hBEEF, 8'h42, 1'b0);

`ifdef SPC_LOADER_CHECKSUM_EN
        do_reset();
        payload_q = '{8'h5A};
        send_image(16'h0100, 1, 0, -1, 1'b0);
        wait_run("img_csum_ok");
        do_reset();
        payload_q = '{8'h5A};
        send_image(16'h0100, 1, 0, -1, 1'b1);
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("csum_bad_error", 32'(out_error), 32'd1);
        chk("csum_bad_run", 32'(out_cpu_run), 32'd0);
        chk("csum_bad_ready", 32'(out_ready), 32'd0);
`endif

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
